sprite_motion_ctrl: RTL and testbench

Frame-synchronous position controller for the on-screen square sprite. Once per video frame it arbitrates between four push-button direction requests (manual mode) and an autonomous diagonal bounce generator (bounce mode). It then updates the sprite's top-left coordinates with edge clamping. It sits between the board keys/switches and the VGA pixel-drawing logic, which consumes `x_pos`/`y_pos` during the next active frame.

---
 rtl/sprite_motion_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position controller: manual push-button moves or
// autonomous diagonal bounce, with edge clamping, one update per accepted frame group.
module sprite_motion_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SIZE            = 50,
  parameter int STEP            = 3,
  parameter int X_INIT          = 300,
  parameter int Y_INIT          = 220,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic       CLK_25,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic [3:0] KEY,
  input  logic       mode,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       upd,
  output logic       edge_hit
);

  localparam int         FCNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [9:0] X_MAX_C   = 10'(H_ACTIVE - SIZE);
  localparam logic [9:0] Y_MAX_C   = 10'(V_ACTIVE - SIZE);
  localparam logic [9:0] STEP_C    = 10'(STEP);
  localparam logic [10:0] STEP_W_C = 11'(STEP);
  localparam logic [9:0] X_INIT_C  = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_C  = 10'(Y_INIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CALC   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          key_meta_r, key_sync_r;
  logic                mode_meta_r, mode_sync_r;
  logic [FCNT_W-1:0]   fcnt_r;
  logic                cmd_mode_r;
  logic [3:0]          cmd_req_r;
  logic                dx_r, dy_r;
  logic [9:0]          nx_r, ny_r, nx_s, ny_s;
  logic                ndx_r, ndy_r, ndx_s, ndy_s;
  logic                flip_r, flip_s;
  logic                tick_ok_s, upd_tick_s;
  logic                hit_x_s, hit_y_s;

  // Comparisons are done 11 bits wide so the sum never wraps before clamping.
  function automatic logic [9:0] inc_f(input logic [9:0] v, input logic [9:0] lim);
    if (({1'b0, v} + STEP_W_C) < {1'b0, lim}) inc_f = v + STEP_C;
    else                                       inc_f = lim;
  endfunction

  function automatic logic [9:0] dec_f(input logic [9:0] v);
    if (v > STEP_C) dec_f = v - STEP_C;
    else            dec_f = 10'd0;
  endfunction

  assign tick_ok_s  = (state_r == ST_IDLE) && frame_tick;
  assign upd_tick_s = tick_ok_s && (fcnt_r == FCNT_LAST);

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge CLK_25) begin
    if (RST) begin
      key_meta_r  <= 4'b1111;
      key_sync_r  <= 4'b1111;
      mode_meta_r <= 1'b0;
      mode_sync_r <= 1'b0;
    end else begin
      key_meta_r  <= KEY;
      key_sync_r  <= key_meta_r;
      mode_meta_r <= mode;
      mode_sync_r <= mode_meta_r;
    end
  end

  // Next-state logic of the update sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (upd_tick_s) state_s = ST_SAMPLE;
        else            state_s = ST_IDLE;
      end
      ST_SAMPLE: state_s = ST_CALC;
      ST_CALC:   state_s = ST_COMMIT;
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State register, frame divider, and command capture on the entering edge of SAMPLE.
  always_ff @(posedge CLK_25) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      fcnt_r     <= '0;
      cmd_mode_r <= 1'b0;
      cmd_req_r  <= 4'b0000;
    end else begin
      state_r <= state_s;
      if (tick_ok_s) begin
        if (fcnt_r == FCNT_LAST) fcnt_r <= '0;
        else                     fcnt_r <= fcnt_r + FCNT_W'(1);
      end
      if (upd_tick_s) begin
        cmd_mode_r <= mode_sync_r;
        cmd_req_r  <= ~key_sync_r;
      end
    end
  end

  assign hit_x_s = dx_r ? (({1'b0, x_pos} + STEP_W_C) >= {1'b0, X_MAX_C}) : (x_pos <= STEP_C);
  assign hit_y_s = dy_r ? (({1'b0, y_pos} + STEP_W_C) >= {1'b0, Y_MAX_C}) : (y_pos <= STEP_C);

  // Next position/direction: bounce moves both axes, manual moves one axis by priority.
  always_comb begin
    nx_s   = x_pos;
    ny_s   = y_pos;
    ndx_s  = dx_r;
    ndy_s  = dy_r;
    flip_s = 1'b0;
    if (cmd_mode_r) begin
      nx_s   = dx_r ? inc_f(x_pos, X_MAX_C) : dec_f(x_pos);
      ny_s   = dy_r ? inc_f(y_pos, Y_MAX_C) : dec_f(y_pos);
      ndx_s  = dx_r ^ hit_x_s;
      ndy_s  = dy_r ^ hit_y_s;
      flip_s = hit_x_s | hit_y_s;
    end else begin
      if (cmd_req_r[3])      nx_s = dec_f(x_pos);
      else if (cmd_req_r[2]) nx_s = inc_f(x_pos, X_MAX_C);
      else if (cmd_req_r[1]) ny_s = inc_f(y_pos, Y_MAX_C);
      else if (cmd_req_r[0]) ny_s = dec_f(y_pos);
      else begin
        nx_s = x_pos;
        ny_s = y_pos;
      end
    end
  end

  // Calculation registers loaded during SAMPLE, committed to the outputs from CALC.
  always_ff @(posedge CLK_25) begin
    if (RST) begin
      nx_r     <= X_INIT_C;
      ny_r     <= Y_INIT_C;
      ndx_r    <= 1'b1;
      ndy_r    <= 1'b1;
      flip_r   <= 1'b0;
      x_pos    <= X_INIT_C;
      y_pos    <= Y_INIT_C;
      dx_r     <= 1'b1;
      dy_r     <= 1'b1;
      upd      <= 1'b0;
      edge_hit <= 1'b0;
    end else begin
      if (state_r == ST_SAMPLE) begin
        nx_r   <= nx_s;
        ny_r   <= ny_s;
        ndx_r  <= ndx_s;
        ndy_r  <= ndy_s;
        flip_r <= flip_s;
      end
      if (state_r == ST_CALC) begin
        x_pos <= nx_r;
        y_pos <= ny_r;
        dx_r  <= ndx_r;
        dy_r  <= ndy_r;
      end
      upd      <= (state_r == ST_CALC);
      edge_hit <= (state_r == ST_CALC) && flip_r;
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed self-checking bench for sprite_motion_ctrl: reset, priority, clamping,
// bounce, frame divider / busy ticks, and reset in the middle of an update.
module tb_sprite_motion_ctrl;

  logic       CLK_25 = 1'b0;
  logic       RST = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] KEY = 4'b1111;
  logic       mode = 1'b0;
  logic [9:0] x1, y1, x2, y2;
  logic       upd1, edge1, upd2, edge2;
  logic       u, e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         upd1_cnt = 0;
  int         upd2_cnt = 0;
  int         c1, c2;

  always #20 CLK_25 = ~CLK_25;

  sprite_motion_ctrl dut1 (
    .CLK_25(CLK_25), .RST(RST), .frame_tick(frame_tick), .KEY(KEY), .mode(mode),
    .x_pos(x1), .y_pos(y1), .upd(upd1), .edge_hit(edge1)
  );

  sprite_motion_ctrl #(.FRAMES_PER_STEP(2)) dut2 (
    .CLK_25(CLK_25), .RST(RST), .frame_tick(frame_tick), .KEY(KEY), .mode(mode),
    .x_pos(x2), .y_pos(y2), .upd(upd2), .edge_hit(edge2)
  );

  always @(negedge CLK_25) begin
    if (upd1 === 1'b1) upd1_cnt++;
    if (upd2 === 1'b1) upd2_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_25) RST = 1'b1;
    repeat (5) @(negedge CLK_25);
    RST = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge CLK_25);
  endtask

  // One frame tick; returns upd/edge_hit of dut1 observed in the cycle after T2.
  task automatic do_tick(output logic uo, output logic eo);
    @(negedge CLK_25) frame_tick = 1'b1;
    @(negedge CLK_25) frame_tick = 1'b0;
    @(negedge CLK_25);
    @(negedge CLK_25);
    uo = upd1;
    eo = edge1;
    @(negedge CLK_25);
  endtask

  initial begin
    // Reset
    do_reset();
    chk("reset_x", x1, 300);
    chk("reset_y", y1, 220);
    chk("reset_upd", upd1, 0);
    chk("reset_edge", edge1, 0);
    repeat (10) @(negedge CLK_25);
    chk("idle_x", x1, 300);
    chk("idle_upd_cnt", upd1_cnt, 0);

    // Priority
    KEY = 4'b0011; settle();
    do_tick(u, e);
    chk("left_over_right_x", x1, 297);
    chk("left_over_right_y", y1, 220);
    chk("left_upd", u, 1);
    chk("left_upd_one_cycle", upd1, 0);
    KEY = 4'b1100; settle();
    do_tick(u, e);
    chk("down_over_up_y", y1, 223);
    chk("down_over_up_x", x1, 297);
    KEY = 4'b1111; settle();
    do_tick(u, e);
    chk("nokey_upd", u, 1);
    chk("nokey_x", x1, 297);
    chk("nokey_y", y1, 223);

    // Left clamp
    KEY = 4'b0111; settle();
    for (int i = 0; i < 100; i++) do_tick(u, e);
    chk("left_clamp_x", x1, 0);
    for (int i = 0; i < 5; i++) do_tick(u, e);
    chk("left_hold_x", x1, 0);
    chk("left_hold_y", y1, 223);

    // Right clamp
    KEY = 4'b1011;
    do_reset(); settle();
    for (int i = 0; i < 96; i++) do_tick(u, e);
    chk("right_t96_x", x1, 588);
    do_tick(u, e);
    chk("right_t97_x", x1, 590);
    chk("manual_no_edge", e, 0);
    for (int i = 0; i < 3; i++) do_tick(u, e);
    chk("right_hold_x", x1, 590);

    // Bounce
    mode = 1'b1;
    do_reset(); settle();
    for (int i = 1; i <= 69; i++) begin
      KEY = 4'($urandom_range(15, 0));
      do_tick(u, e);
    end
    chk("bounce_t69_y", y1, 427);
    chk("bounce_t69_edge", e, 0);
    KEY = 4'b0000;
    do_tick(u, e);
    chk("bounce_t70_y", y1, 430);
    chk("bounce_t70_x", x1, 510);
    chk("bounce_t70_edge", e, 1);
    for (int i = 71; i <= 96; i++) begin
      KEY = 4'($urandom_range(15, 0));
      do_tick(u, e);
    end
    chk("bounce_t96_x", x1, 588);
    chk("bounce_t96_y", y1, 352);
    do_tick(u, e);
    chk("bounce_t97_x", x1, 590);
    chk("bounce_t97_y", y1, 349);
    chk("bounce_t97_edge", e, 1);
    do_tick(u, e);
    chk("bounce_t98_x", x1, 587);
    chk("bounce_t98_y", y1, 346);
    chk("bounce_t98_edge", e, 0);

    // Divider and busy ticks
    mode = 1'b0;
    KEY = 4'b1011;
    do_reset(); settle();
    c2 = upd2_cnt;
    for (int i = 0; i < 4; i++) do_tick(u, e);
    chk("div2_upd_pulses", upd2_cnt - c2, 2);
    chk("div2_x", x2, 306);
    chk("div2_y", y2, 220);
    chk("div2_edge", edge2, 0);
    chk("div1_x", x1, 312);
    c1 = upd1_cnt;
    c2 = upd2_cnt;
    do_tick(u, e);
    @(negedge CLK_25) frame_tick = 1'b1;
    @(negedge CLK_25);
    @(negedge CLK_25) frame_tick = 1'b0;
    repeat (4) @(negedge CLK_25);
    do_tick(u, e);
    chk("busy_dut1_pulses", upd1_cnt - c1, 3);
    chk("busy_dut1_x", x1, 321);
    chk("busy_dut2_pulses", upd2_cnt - c2, 1);
    chk("busy_dut2_x", x2, 309);

    // Reset in the middle of an update
    KEY = 4'b0111;
    do_reset(); settle();
    do_tick(u, e);
    chk("midrst_start_x", x1, 297);
    KEY = 4'b1011; settle();
    c1 = upd1_cnt;
    @(negedge CLK_25) frame_tick = 1'b1;
    @(negedge CLK_25) begin frame_tick = 1'b0; RST = 1'b1; end
    @(negedge CLK_25) RST = 1'b0;
    @(negedge CLK_25);
    chk("midrst_x", x1, 300);
    chk("midrst_upd", upd1, 0);
    repeat (4) @(negedge CLK_25);
    chk("midrst_no_pulse", upd1_cnt - c1, 0);
    do_tick(u, e);
    chk("midrst_after_x", x1, 303);
    chk("midrst_after_upd", u, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
